// File: rtl/attn_pkg.sv
// attn_pkg: shared FP32 helpers and drain FSM state for the attention-score drain
package attn_pkg;
  localparam logic [31:0] FP32_NEG_INF = 32'hFF80_0000;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} drain_state_t;
  // Monotonic unsigned key: -0 sorts below +0, NaNs fall where their bits put them
  function automatic logic [31:0] fp32_key(input logic [31:0] x);
    return x[31] ? ~x : x ^ 32'h8000_0000;
  endfunction
endpackage

// File: rtl/attention_score_drain_if.sv
// attention_score_drain_if: score SRAM read port plus softmax-bound score stream
interface attention_score_drain_if #(
  parameter int T = 8,
  parameter int DATA_W = 32
);
  localparam int T_W = (T <= 1) ? 1 : $clog2(T);
  logic              score_re;
  logic [T_W-1:0]    score_tq;
  logic [T_W-1:0]    score_tk;
  logic [DATA_W-1:0] score_rdata;
  logic              score_rvalid;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [T_W-1:0]    out_tq;
  logic [T_W-1:0]    out_tk;
  logic              out_last_col;
  logic              out_last;
  logic [DATA_W-1:0] row_max;
  logic              row_max_valid;
  modport master (
    output score_re, score_tq, score_tk,
    input  score_rdata, score_rvalid,
    output out_valid, out_data, out_tq, out_tk, out_last_col, out_last, row_max, row_max_valid,
    input  out_ready
  );
  modport slave (
    input  score_re, score_tq, score_tk,
    output score_rdata, score_rvalid,
    input  out_valid, out_data, out_tq, out_tk, out_last_col, out_last, row_max, row_max_valid,
    output out_ready
  );
endinterface

// File: rtl/fp32_max2.sv
// fp32_max2: combinational maximum of two FP32 values by total-order key
module fp32_max2
  import attn_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  assign y_o = (fp32_key(b_i) > fp32_key(a_i)) ? b_i : a_i;
endmodule

// File: rtl/attention_score_drain.sv
// attention_score_drain: row-major T x T score readout with causal mask and running row max
module attention_score_drain
  import attn_pkg::*;
#(
  parameter int T = 8,
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic causal_en,
  output logic busy,
  output logic done,
  attention_score_drain_if.master bus
);
  localparam int T_W = (T <= 1) ? 1 : $clog2(T);
  localparam logic [T_W-1:0] LAST = T_W'(T - 1);
  drain_state_t      state_q;
  logic [T_W-1:0]    tq_q, tk_q;
  logic              causal_q, done_q;
  logic [DATA_W-1:0] data_q, max_q, max_d;
  logic              masked, last_col, last_elem;
  assign masked    = causal_q && (tk_q > tq_q);
  assign last_col  = tk_q == LAST;
  assign last_elem = last_col && (tq_q == LAST);
  fp32_max2 u_max (.a_i(max_q), .b_i(bus.score_rdata), .y_o(max_d));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tq_q     <= '0;
      tk_q     <= '0;
      causal_q <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
      max_q    <= FP32_NEG_INF;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q  <= ISSUE;
          tq_q     <= '0;
          tk_q     <= '0;
          causal_q <= causal_en;
          done_q   <= 1'b0;
        end
        ISSUE: begin
          if (tk_q == '0) max_q <= FP32_NEG_INF;
          if (masked) data_q <= FP32_NEG_INF;
          state_q <= masked ? EMIT : WAIT;
        end
        WAIT: if (bus.score_rvalid) begin
          data_q  <= bus.score_rdata;
          max_q   <= max_d;
          state_q <= EMIT;
        end
        EMIT: if (bus.out_ready) begin
          if (last_elem) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            tk_q    <= last_col ? '0 : tk_q + 1'b1;
            tq_q    <= last_col ? tq_q + 1'b1 : tq_q;
            state_q <= ISSUE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy              = state_q != IDLE;
  assign done              = done_q;
  assign bus.score_re      = (state_q == ISSUE) && !masked;
  assign bus.score_tq      = tq_q;
  assign bus.score_tk      = tk_q;
  assign bus.out_valid     = state_q == EMIT;
  assign bus.out_data      = data_q;
  assign bus.out_tq        = tq_q;
  assign bus.out_tk        = tk_q;
  assign bus.out_last_col  = last_col;
  assign bus.out_last      = last_elem;
  assign bus.row_max       = max_q;
  assign bus.row_max_valid = (state_q == EMIT) && bus.out_ready && last_col;
endmodule

// File: tb/tb_attention_score_drain.sv
// tb_attention_score_drain: scoreboard bench with SRAM responder, random stalls and reset replay
module tb_attention_score_drain;
  localparam int T = 4;
  localparam logic [31:0] NINF = 32'hFF80_0000;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, causal_en = 1'b0;
  logic busy, done;
  attention_score_drain_if #(.T(T)) bus();
  attention_score_drain #(.T(T)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .causal_en(causal_en),
    .busy(busy), .done(done), .bus(bus.master)
  );
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  tq, tk;
    logic [31:0] data, rmax;
    logic        lc, l;
  } elem_t;
  typedef struct {
    bit               causal;
    int               pat;
    int               lmax;
    int               rdy;
    int               exp_re;
    bit               chk_max;
    logic [3:0][31:0] rmax;
  } vec_t;

  elem_t       exp_q[$];
  vec_t        vecs[5];
  logic [31:0] mem[4][4];
  logic [31:0] ramp[16];
  logic [31:0] pend_data;
  logic [3:0][31:0] cur_rmax;
  bit          cur_chk;
  int          lat_max, rdy_pct, pend, n_re, n_hs;
  int          n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // a > b in FP32 order, argued from sign and magnitude
  function automatic bit fp_gt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return b[31];
    return a[31] ? (a[30:0] < b[30:0]) : (a[30:0] > b[30:0]);
  endfunction

  task automatic tick();
    elem_t e;
    @(negedge clk);
    bus.score_rvalid = 1'b0;
    bus.score_rdata  = $urandom;
    if (bus.score_re) begin
      n_re++;
      chk("one_outstanding", 32'(pend), 32'd0);
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        bus.score_rvalid = 1'b1;
        bus.score_rdata  = pend_data;
      end
    end else if (bus.out_valid && $urandom_range(3) == 0) begin
      bus.score_rvalid = 1'b1;
      bus.score_rdata  = 32'hDEAD_BEEF;
    end
    if (bus.score_re) begin
      pend      = (lat_max <= 1) ? 1 : int'($urandom_range(lat_max, 1));
      pend_data = mem[bus.score_tq][bus.score_tk];
    end
    bus.out_ready = ($urandom_range(99) < rdy_pct);
    #1;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) chk("extra_elem", 32'd1, 32'd0);
      else begin
        e = exp_q[0];
        chk("out_tq", 32'(bus.out_tq), 32'(e.tq));
        chk("out_tk", 32'(bus.out_tk), 32'(e.tk));
        chk("out_data", bus.out_data, e.data);
        chk("out_last_col", 32'(bus.out_last_col), 32'(e.lc));
        chk("out_last", 32'(bus.out_last), 32'(e.l));
        chk("row_max", bus.row_max, e.rmax);
        chk("row_max_valid", 32'(bus.row_max_valid), 32'(e.lc & bus.out_ready));
        if (bus.out_ready) begin
          if (cur_chk && e.lc) chk("row_max_const", bus.row_max, cur_rmax[e.tq]);
          void'(exp_q.pop_front());
          n_hs++;
        end
      end
    end
  endtask

  task automatic load(input vec_t v);
    logic [31:0] rm, d;
    bit m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        case (v.pat)
          0: mem[i][j] = ramp[4*i+j];
          1: mem[i][j] = (j == 0) ? 32'hBF80_0000 : (j == 1) ? 32'h8000_0000 :
                         (j == 2) ? 32'h0000_0000 : 32'hC060_0000;
          default: mem[i][j] = $urandom;
        endcase
      end
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      rm = NINF;
      for (int j = 0; j < 4; j++) begin
        m = v.causal && (j > i);
        d = m ? NINF : mem[i][j];
        if (!m && fp_gt(d, rm)) rm = d;
        exp_q.push_back('{tq: 2'(i), tk: 2'(j), data: d, rmax: rm, lc: (j == 3), l: (i == 3 && j == 3)});
      end
    end
    lat_max = v.lmax; rdy_pct = v.rdy; cur_chk = v.chk_max; cur_rmax = v.rmax;
    n_re = 0; n_hs = 0; pend = 0;
  endtask

  task automatic run_case(input vec_t v);
    bit fin;
    load(v);
    causal_en = v.causal;
    start = 1'b1;
    tick();
    start = 1'b0;
    causal_en = ~v.causal;
    fin = 1'b0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      if (c == 20) start = 1'b1;
      tick();
      start = 1'b0;
      fin = done;
    end
    chk("done_set", 32'(done), 32'd1);
    chk("busy_clear", 32'(busy), 32'd0);
    chk("re_count", 32'(n_re), 32'(v.exp_re));
    chk("elem_count", 32'(n_hs), 32'd16);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit hit;
    bus.out_ready = 1'b0; bus.score_rvalid = 1'b0; bus.score_rdata = '0;
    ramp = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
             32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000,
             32'h4100_0000, 32'h4110_0000, 32'h4120_0000, 32'h4130_0000,
             32'h4140_0000, 32'h4150_0000, 32'h4160_0000, 32'h4170_0000};
    vecs[0] = '{causal: 0, pat: 0, lmax: 1, rdy: 100, exp_re: 16, chk_max: 1,
                rmax: {32'h4170_0000, 32'h4130_0000, 32'h40E0_0000, 32'h4040_0000}};
    vecs[1] = '{causal: 1, pat: 0, lmax: 1, rdy: 100, exp_re: 10, chk_max: 1,
                rmax: {32'h4170_0000, 32'h4120_0000, 32'h40A0_0000, 32'h0000_0000}};
    vecs[2] = '{causal: 0, pat: 1, lmax: 1, rdy: 100, exp_re: 16, chk_max: 1, rmax: '0};
    vecs[3] = '{causal: 0, pat: 2, lmax: 4, rdy: 30, exp_re: 16, chk_max: 0, rmax: '0};
    vecs[4] = '{causal: 1, pat: 2, lmax: 4, rdy: 30, exp_re: 10, chk_max: 0, rmax: '0};
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_score_re", 32'(bus.score_re), 32'd0);
    chk("rst_row_max", bus.row_max, NINF);
    chk("rst_out_data", bus.out_data, 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) run_case(vecs[k]);
    load(vecs[0]);
    causal_en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 500 && !hit; c++) begin
      tick();
      hit = bus.score_re && bus.score_tq == 2'd2 && bus.score_tk == 2'd1;
    end
    chk("reach_2_1", 32'(hit), 32'd1);
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_row_max", bus.row_max, NINF);
    rst_n = 1'b1;
    pend = 0;
    bus.score_rvalid = 1'b1;
    bus.score_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.score_rvalid = 1'b0;
    chk("idle_after_rst", 32'(busy), 32'd0);
    run_case(vecs[0]);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/attention_score_drain.md
# attention_score_drain

Sequencer downstream of the attention-score GEMM. After the score matrix C[T][T] has been produced, it reads the matrix out of the score SRAM read port in row-major order. It optionally applies a causal mask, tracks a running FP32 row maximum, and streams each score over a valid/ready interface. The stream, with per-row max sideband, feeds the softmax stage.

## Interface
Parameters:
- T, 8, tokens per tile (matrix is T×T)
- DATA_W, 32, score width; only 32 (FP32) is supported
- T_W, derived = (T<=1)?1:$clog2(T), index width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  level; sampled only in IDLE
- causal_en  in  1  sampled at accepted start; masks tk>tq
- busy  out  1  high in any state other than IDLE
- done  out  1  sticky; set on final element handshake, cleared on accepted start
- score_re  out  1  one-cycle read request
- score_tq  out  T_W  read row
- score_tk  out  T_W  read column
- score_rdata  in  32  read data
- score_rvalid  in  1  read data valid, latency ≥1 cycle
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_data  out  32  score, or masked value 0xFF800000
- out_tq, out_tk  out  T_W  element coordinates
- out_last_col  out  1  tk==T-1
- out_last  out  1  tq==T-1 and tk==T-1
- row_max  out  32  running max of the current row, including the element on out_data
- row_max_valid  out  1  = out_valid & out_ready & out_last_col

## Operation
- FSM states:
  - IDLE: start → ISSUE; clears counters and done; latches causal_en.
  - ISSUE:
    - If causal_en and tk>tq: load 0xFF800000 into the out register, go to EMIT. No SRAM read is issued.
    - Otherwise: drive score_re=1 with (tq,tk) for exactly this cycle, go to WAIT.
  - WAIT: on score_rvalid, capture score_rdata into the out register and update row_max, go to EMIT. The read has no timeout.
  - EMIT: out_valid=1 and holds until out_ready.
    - On handshake with out_last: set done, go to IDLE.
    - On other handshakes: advance tk (wrapping to 0 and incrementing tq at T-1), go to ISSUE.
- Row max:
  - Reset to 0xFF800000 (-inf) at the start of each row, i.e. on ISSUE with tk==0.
  - Updated in the same cycle the element is captured. Masked elements never change it.
  - The diagonal element is always read, so every row max comes from real data.
- FP32 compare uses the ordering key: key = sign ? ~x : x^32'h8000_0000, compared unsigned. -0 < +0. NaN has no special handling; it is ordered by its key.
- start while busy is ignored. score_rvalid outside WAIT is ignored.
- Only one read is outstanding at any time.

## Timing
- Reset values: every output is 0 except row_max = 0xFF800000; FSM is in IDLE.
- Reset mid-operation: immediate return to IDLE, done=0, out_valid drops the next cycle. An in-flight rvalid is discarded.
- Unmasked element: ISSUE(1) + read latency L + EMIT(≥1). With out_ready tied high this is 2+L cycles per element.
- Masked element: ISSUE(1) + EMIT(≥1) = 2 cycles.
- While out_valid=1 without out_ready, out_data, out_tq, out_tk, out_last_col, out_last and row_max are stable.
- done rises the cycle after the final handshake. busy falls in the same cycle.
- A start accepted in IDLE gives busy=1 the next cycle. The first score_re appears on that cycle.

## Structure
- Shared package attn_pkg: FP32_NEG_INF constant, function fp32_key(), and the drain_state_t enum {IDLE, ISSUE, WAIT, EMIT}.
- Sub-module fp32_max2: combinational max of two FP32 values using fp32_key. It is instantiated once for the row-max update.
- All other logic is the FSM plus the tq/tk counters in this module.

## Test plan
- T=4, causal_en=0, C[i][j]=float(4i+j), L=1, out_ready=1 → 16 elements in row-major order. out_last only on (3,3). row_max = 3.0, 7.0, 11.0, 15.0 on the row_max_valid pulses. done=1 afterwards.
- T=4, causal_en=1 → exactly 10 score_re pulses. Outputs with tk>tq carry 0xFF800000. Row 0 row_max equals C[0][0].
- Row values {-1.0, -0.0, +0.0, -3.5} (0xBF800000, 0x80000000, 0x00000000, 0xC0600000) → row_max = 0x00000000.
- Randomised out_ready at 30% and L randomly 1–4 → outputs stay stable during stalls, no element is lost or duplicated, and never more than one read is outstanding.
- Pulse start while busy, and inject a stray rvalid during EMIT → no restart, no data corruption, and the element count stays 16.
- rst_n low during element (2,1) → next cycle busy=0, out_valid=0, done=0. A fresh start then replays from (0,0).
